axi_riscv_lrsc_resv_ctrl: RTL and testbench

//  Reservation-set controller for the AXI RISC-V LR/SC adapter. Holds up to NUM_RESV
//  (AXI ID, address-granule) reservations, serves one operation at a time over a

---
 rtl/axi_riscv_lrsc_resv_ctrl.sv | 174 +++++++++++++++++
 tb/tb_axi_riscv_lrsc_resv_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/axi_riscv_lrsc_resv_ctrl.sv
// Reservation-set controller for the LR/SC adapter: tracks (ID, granule) reservations
// and answers one LR / SC / WRITE / CLEAR operation at a time over a valid/ready pair.
module axi_riscv_lrsc_resv_ctrl #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned NUM_RESV       = 4,
  parameter int unsigned GRANULE_BITS   = 3,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_BEGIN = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_END   = '0,
  localparam int unsigned CNT_W = $clog2(NUM_RESV + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      op_valid_i,
  output logic                      op_ready_o,
  input  logic [1:0]                op_type_i,
  input  logic [AXI_ID_WIDTH-1:0]   op_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] op_addr_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic                      res_ok_o,
  output logic [AXI_ID_WIDTH-1:0]   res_id_o,
  output logic [CNT_W-1:0]          resv_cnt_o
);

  localparam int unsigned IW = (NUM_RESV > 1) ? $clog2(NUM_RESV) : 1;
  localparam int unsigned GW = AXI_ADDR_WIDTH - GRANULE_BITS;
  localparam logic [AXI_ADDR_WIDTH-1:0] RANGE_SPAN = ADDR_END - ADDR_BEGIN;
  localparam logic [1:0] OP_LR = 2'b00, OP_SC = 2'b01, OP_WRITE = 2'b10, OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;

  state_e                    state_reg;
  logic [1:0]                op_type_reg;
  logic [AXI_ID_WIDTH-1:0]   op_id_reg;
  logic [AXI_ADDR_WIDTH-1:0] op_addr_reg;

  logic [NUM_RESV-1:0]       valid_reg, valid_next;
  logic [AXI_ID_WIDTH-1:0]   id_reg   [NUM_RESV];
  logic [AXI_ID_WIDTH-1:0]   id_next  [NUM_RESV];
  logic [GW-1:0]             gran_reg [NUM_RESV];
  logic [GW-1:0]             gran_next[NUM_RESV];
  logic [IW-1:0]             ptr_reg, ptr_next;
  logic                      ok_next;

  logic [NUM_RESV-1:0]       id_match, gran_match;
  logic [GW-1:0]             op_gran;
  logic [AXI_ADDR_WIDTH-1:0] addr_off;
  logic                      in_range;
  logic                      id_hit, free_hit;
  logic [IW-1:0]             id_idx, free_idx;
  logic [CNT_W-1:0]          cnt;

  // Offset compare wraps for addresses below ADDR_BEGIN, so one unsigned test covers both ends.
  assign addr_off = op_addr_reg - ADDR_BEGIN;
  assign in_range = (addr_off <= RANGE_SPAN);
  assign op_gran  = op_addr_reg[AXI_ADDR_WIDTH-1:GRANULE_BITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RESV; gi++) begin : g_match
      assign id_match[gi]   = valid_reg[gi] && (id_reg[gi] == op_id_reg);
      assign gran_match[gi] = valid_reg[gi] && (gran_reg[gi] == op_gran);
    end
  endgenerate

  always_comb begin
    valid_next = valid_reg;
    id_next    = id_reg;
    gran_next  = gran_reg;
    ptr_next   = ptr_reg;
    ok_next    = 1'b0;
    id_hit     = 1'b0;
    id_idx     = '0;
    free_hit   = 1'b0;
    free_idx   = '0;
    // Scan downwards so the lowest matching / free index wins.
    for (int i = NUM_RESV - 1; i >= 0; i--) begin
      if (id_match[i]) begin
        id_hit = 1'b1;
        id_idx = IW'(i);
      end
      if (!valid_reg[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
    case (op_type_reg)
      OP_LR: begin
        if (in_range) begin
          ok_next = 1'b1;
          if (id_hit) begin
            gran_next[id_idx] = op_gran;
          end else if (free_hit) begin
            valid_next[free_idx] = 1'b1;
            id_next[free_idx]    = op_id_reg;
            gran_next[free_idx]  = op_gran;
          end else begin
            id_next[ptr_reg]   = op_id_reg;
            gran_next[ptr_reg] = op_gran;
            ptr_next = (ptr_reg == IW'(NUM_RESV - 1)) ? '0 : ptr_reg + 1'b1;
          end
        end
      end
      OP_SC: begin
        if (in_range) begin
          ok_next = id_hit && gran_match[id_idx];
          if (id_hit) valid_next[id_idx] = 1'b0;
          if (ok_next) begin
            for (int i = 0; i < NUM_RESV; i++) begin
              if (gran_match[i]) valid_next[i] = 1'b0;
            end
          end
        end
      end
      OP_WRITE: begin
        ok_next = 1'b1;
        if (in_range) valid_next = valid_reg & ~gran_match;
      end
      default: begin
        ok_next    = 1'b1;
        valid_next = '0;
      end
    endcase
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_RESV; i++) cnt = cnt + CNT_W'(valid_reg[i]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      valid_reg   <= '0;
      ptr_reg     <= '0;
      res_valid_o <= 1'b0;
      res_ok_o    <= 1'b0;
      res_id_o    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (op_valid_i) begin
            op_type_reg <= op_type_i;
            op_id_reg   <= op_id_i;
            op_addr_reg <= op_addr_i;
            state_reg   <= LOOKUP;
          end
        end
        LOOKUP: begin
          valid_reg   <= valid_next;
          id_reg      <= id_next;
          gran_reg    <= gran_next;
          ptr_reg     <= ptr_next;
          res_ok_o    <= ok_next;
          res_id_o    <= op_id_reg;
          res_valid_o <= 1'b1;
          state_reg   <= RESP;
        end
        RESP: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign op_ready_o = rst_ni && (state_reg == IDLE);
  assign resv_cnt_o = cnt;

endmodule

// File: tb/tb_axi_riscv_lrsc_resv_ctrl.sv
// Directed bench for the reservation controller: a slot-level reservation model is
// compared against the DUT every cycle, with hand-computed literals per operation.
module tb_axi_riscv_lrsc_resv_ctrl;

  localparam int AW = 32;
  localparam int IDW = 4;
  localparam int NR = 4;
  localparam int GB = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            op_valid, op_ready;
  logic [1:0]      op_type;
  logic [IDW-1:0]  op_id;
  logic [AW-1:0]   op_addr;
  logic            res_valid, res_ready, res_ok;
  logic [IDW-1:0]  res_id;
  logic [2:0]      resv_cnt;

  axi_riscv_lrsc_resv_ctrl #(
    .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IDW), .NUM_RESV(NR), .GRANULE_BITS(GB),
    .ADDR_BEGIN(32'h0000_0000), .ADDR_END(32'h0000_FFFF)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .op_valid_i(op_valid), .op_ready_o(op_ready), .op_type_i(op_type),
    .op_id_i(op_id), .op_addr_i(op_addr),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_ok_o(res_ok),
    .res_id_o(res_id), .resv_cnt_o(resv_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reservation model: NR slots, each (valid, id, granule), plus a round-robin victim slot.
  bit             m_v  [NR];
  logic [IDW-1:0] m_id [NR];
  logic [AW-1:0]  m_g  [NR];
  int             m_ptr;

  bit             exp_ready, exp_rv, exp_ok;
  logic [IDW-1:0] exp_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_v[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) m_v[i] = 1'b0;
    m_ptr = 0;
  endtask

  task automatic model_apply(input logic [1:0] t, input logic [IDW-1:0] id,
                             input logic [AW-1:0] a, output bit ok);
    bit            inr = (a <= 32'h0000_FFFF);
    logic [AW-1:0] g   = a >> GB;
    int            own = -1;
    int            free = -1;
    for (int i = NR - 1; i >= 0; i--) begin
      if (m_v[i] && m_id[i] == id) own = i;
      if (!m_v[i]) free = i;
    end
    ok = 1'b0;
    case (t)
      2'b00: if (inr) begin
        ok = 1'b1;
        if (own >= 0) m_g[own] = g;
        else if (free >= 0) begin m_v[free] = 1'b1; m_id[free] = id; m_g[free] = g; end
        else begin m_id[m_ptr] = id; m_g[m_ptr] = g; m_ptr = (m_ptr + 1) % NR; end
      end
      2'b01: if (inr && own >= 0) begin
        ok = (m_g[own] == g);
        m_v[own] = 1'b0;
        if (ok) for (int i = 0; i < NR; i++) if (m_g[i] == g) m_v[i] = 1'b0;
      end
      2'b10: begin
        ok = 1'b1;
        if (inr) for (int i = 0; i < NR; i++) if (m_g[i] == g) m_v[i] = 1'b0;
      end
      default: begin ok = 1'b1; for (int i = 0; i < NR; i++) m_v[i] = 1'b0; end
    endcase
  endtask

  // Per-cycle comparison against the model and the expected handshake phase.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("op_ready", op_ready, exp_ready);
      chk("res_valid", res_valid, exp_rv);
      chk("resv_cnt", resv_cnt, model_cnt());
      if (exp_rv) begin
        chk("res_ok", res_ok, exp_ok);
        chk("res_id", res_id, exp_id);
      end
    end
  end

  // Called #1 after a posedge with the DUT idle; returns #1 after the edge that frees it again.
  task automatic do_op(input logic [1:0] t, input logic [IDW-1:0] id, input logic [AW-1:0] a,
                       input int hold, input bit lit_ok, input int lit_cnt);
    bit ok;
    op_valid = 1'b1; op_type = t; op_id = id; op_addr = a;
    @(posedge clk); #1;
    op_valid = 1'b0; exp_ready = 1'b0;
    @(posedge clk); #1;
    model_apply(t, id, a, ok);
    exp_ok = ok; exp_id = id; exp_rv = 1'b1;
    chk("lit_ok", res_ok, lit_ok);
    chk("lit_cnt", resv_cnt, lit_cnt);
    chk("model_ok", ok, lit_ok);
    $display("op type=%0d id=%0d addr=%h ok=%0d cnt=%0d", t, id, a, res_ok, resv_cnt);
    repeat (hold) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0; exp_rv = 1'b0; exp_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
    op_type = '0; op_id = '0; op_addr = '0;
    exp_ready = 1'b0; exp_rv = 1'b0; exp_ok = 1'b0; exp_id = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_ok", res_ok, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_cnt", resv_cnt, 0);
    chk("rst_op_ready", op_ready, 0);
    rst_n = 1'b1; exp_ready = 1'b1;
    @(posedge clk); #1;

    do_op(2'b00, 4'd1, 32'h1000, 0, 1'b1, 1);
    do_op(2'b01, 4'd1, 32'h1004, 0, 1'b1, 0);
    do_op(2'b01, 4'd1, 32'h1000, 0, 1'b0, 0);

    do_op(2'b00, 4'd1, 32'h1000, 0, 1'b1, 1);
    do_op(2'b00, 4'd2, 32'h1000, 0, 1'b1, 2);
    do_op(2'b10, 4'd3, 32'h1006, 0, 1'b1, 0);
    do_op(2'b01, 4'd2, 32'h1000, 0, 1'b0, 0);

    do_op(2'b11, 4'd0, 32'h0, 0, 1'b1, 0);
    for (int i = 0; i < 5; i++)
      do_op(2'b00, 4'(i), 32'h2000 + 32'(i) * 32'h10, 0, 1'b1, (i < 4) ? i + 1 : 4);
    do_op(2'b01, 4'd0, 32'h2000, 0, 1'b0, 4);
    do_op(2'b01, 4'd4, 32'h2040, 0, 1'b1, 3);

    do_op(2'b00, 4'd5, 32'h2_0000, 5, 1'b0, 3);
    do_op(2'b01, 4'd1, 32'h2_0008, 0, 1'b0, 3);
    do_op(2'b10, 4'd1, 32'h2_0010, 0, 1'b1, 3);
    do_op(2'b00, 4'd1, 32'h3000, 0, 1'b1, 3);
    do_op(2'b01, 4'd1, 32'h2010, 0, 1'b0, 2);
    do_op(2'b00, 4'd2, 32'h3000, 0, 1'b1, 2);
    do_op(2'b00, 4'd3, 32'h3000, 0, 1'b1, 2);
    do_op(2'b01, 4'd3, 32'h3000, 2, 1'b1, 0);
    do_op(2'b00, 4'd6, 32'h4000, 0, 1'b1, 1);

    // Reset asserted while an LR is in LOOKUP: its result must never appear.
    op_valid = 1'b1; op_type = 2'b00; op_id = 4'd7; op_addr = 32'h5000;
    @(posedge clk); #1;
    op_valid = 1'b0; exp_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    model_clear();
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_cnt", resv_cnt, 0);
    $display("mid-op reset res_valid=%0d cnt=%0d", res_valid, resv_cnt);
    @(posedge clk); #1;
    rst_n = 1'b1; exp_ready = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("post_rst_res_valid", res_valid, 0);

    do_op(2'b00, 4'd8, 32'h6000, 0, 1'b1, 1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
